// File: rtl/bitwise_arbiter_if.sv
// Bundle between two requesters, the arbiter, its result consumer and the
// shared bitwise unit.
//
// Handshake rules: a transfer happens on a rising clk edge where valid and
// ready are both high. req_valid[i] with its op/a/b fields may be dropped or
// changed freely until req_ready[i] is seen. rsp_valid, rsp_id and rsp_q stay
// stable from the edge that raises rsp_valid until the edge where rsp_ready is
// high. rsp_ready may be high at any time and only counts while rsp_valid is high.
interface bitwise_arbiter_if #(
  parameter int WIDTH = 7
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [3:0]         req_op;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_q;
  logic [1:0]         alu_op;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH-1:0]   alu_q;

  // Arbiter side
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_q,
    output req_ready, rsp_valid, rsp_id, rsp_q, alu_op, alu_a, alu_b
  );

  // Environment side: requesters, consumer and the bitwise unit
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_q,
    input  req_ready, rsp_valid, rsp_id, rsp_q, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/bitwise_arbiter.sv
// Two-requester round-robin front end for a shared bitwise unit with a fixed
// pipeline latency. One operation is in flight at a time: accept, wait for the
// unit, hold the result until the consumer takes it, then arbitrate again.
module bitwise_arbiter #(
  parameter int WIDTH       = 7,
  parameter int ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  bitwise_arbiter_if.slave  bus,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT = 3'(ALU_LATENCY);

  state_t           state;
  logic [2:0]       counter;
  logic             last_grant;
  logic             grant_id;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Round-robin pick: a lone requester wins, a tie goes to whoever lost last time
  always_comb begin
    grant_id = 1'b0;
    case (bus.req_valid)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_op = grant_id ? bus.req_op[3:2]            : bus.req_op[1:0];
    sel_a  = grant_id ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
    sel_b  = grant_id ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
  end

  // Ready only in IDLE, one-hot on the winner, so acceptance needs no extra state
  assign bus.req_ready = (state == IDLE && (|bus.req_valid))
                         ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Control FSM and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      counter       <= '0;
      last_grant    <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_q     <= '0;
      bus.alu_op    <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            bus.alu_op <= sel_op;
            bus.alu_a  <= sel_a;
            bus.alu_b  <= sel_b;
            bus.rsp_id <= grant_id;
            last_grant <= grant_id;
            counter    <= LAT;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // Operands were presented at the accept edge; the unit is settled once
          // the counter has run down to zero, so that edge captures its result.
          if (counter == 3'd0) begin
            bus.rsp_q     <= bus.alu_q;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            counter <= counter - 3'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_arbiter.sv
// Bench for bitwise_arbiter: three instances (latency 0, 1, 3), each with its
// own bitwise unit model; stimulus is steered to one instance at a time.
module tb_bitwise_arbiter;

  localparam int W = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  // clock/reset block
  always #5 clk = ~clk;

  // shared drive signals and instance select (0: lat0, 1: lat1, 2: lat3)
  int         sel = 1;
  logic [1:0] drv_valid = 2'b00;
  logic [3:0] drv_op = '0;
  logic [2*W-1:0] drv_a = '0;
  logic [2*W-1:0] drv_b = '0;
  logic       drv_rsp_ready = 1'b1;

  bitwise_arbiter_if #(.WIDTH(W)) if0 ();
  bitwise_arbiter_if #(.WIDTH(W)) if1 ();
  bitwise_arbiter_if #(.WIDTH(W)) if3 ();

  logic       busy0, busy1, busy3;
  logic [1:0] st0, st1, st3;

  bitwise_arbiter #(.WIDTH(W), .ALU_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .busy(busy0), .state_dbg(st0));
  bitwise_arbiter #(.WIDTH(W), .ALU_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1), .state_dbg(st1));
  bitwise_arbiter #(.WIDTH(W), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave), .busy(busy3), .state_dbg(st3));

  function automatic logic [W-1:0] alu_f(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic int lat_of(input int s);
    case (s)
      0:       return 0;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  // request / consumer wiring
  assign if0.req_valid = (sel == 0) ? drv_valid : 2'b00;
  assign if1.req_valid = (sel == 1) ? drv_valid : 2'b00;
  assign if3.req_valid = (sel == 2) ? drv_valid : 2'b00;
  assign if0.req_op = drv_op;  assign if1.req_op = drv_op;  assign if3.req_op = drv_op;
  assign if0.req_a  = drv_a;   assign if1.req_a  = drv_a;   assign if3.req_a  = drv_a;
  assign if0.req_b  = drv_b;   assign if1.req_b  = drv_b;   assign if3.req_b  = drv_b;
  assign if0.rsp_ready = drv_rsp_ready;
  assign if1.rsp_ready = drv_rsp_ready;
  assign if3.rsp_ready = drv_rsp_ready;

  // bitwise unit models with matching latencies
  logic [W-1:0] q1;
  logic [W-1:0] p3 [3];
  assign if0.alu_q = alu_f(if0.alu_op, if0.alu_a, if0.alu_b);
  always_ff @(posedge clk) q1 <= alu_f(if1.alu_op, if1.alu_a, if1.alu_b);
  assign if1.alu_q = q1;
  always_ff @(posedge clk) begin
    p3[0] <= alu_f(if3.alu_op, if3.alu_a, if3.alu_b);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign if3.alu_q = p3[2];

  // view of the selected instance
  logic [1:0]   cur_ready;
  logic         cur_rsp_valid, cur_rsp_id, cur_busy;
  logic [W-1:0] cur_rsp_q, cur_alu_a, cur_alu_b;
  logic [1:0]   cur_state;
  always_comb begin
    case (sel)
      0: begin
        cur_ready = if0.req_ready; cur_rsp_valid = if0.rsp_valid; cur_rsp_id = if0.rsp_id;
        cur_rsp_q = if0.rsp_q; cur_busy = busy0; cur_alu_a = if0.alu_a;
        cur_alu_b = if0.alu_b; cur_state = st0;
      end
      2: begin
        cur_ready = if3.req_ready; cur_rsp_valid = if3.rsp_valid; cur_rsp_id = if3.rsp_id;
        cur_rsp_q = if3.rsp_q; cur_busy = busy3; cur_alu_a = if3.alu_a;
        cur_alu_b = if3.alu_b; cur_state = st3;
      end
      default: begin
        cur_ready = if1.req_ready; cur_rsp_valid = if1.rsp_valid; cur_rsp_id = if1.rsp_id;
        cur_rsp_q = if1.rsp_q; cur_busy = busy1; cur_alu_a = if1.alu_a;
        cur_alu_b = if1.alu_b; cur_state = st1;
      end
    endcase
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic model_last = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reset asserted mid-cycle; outputs must clear before the next edge
  task automatic do_reset();
    drv_valid = 2'b00;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(cur_rsp_valid), 32'd0);
    check("rst_busy", 32'(cur_busy), 32'd0);
    check("rst_req_ready", 32'(cur_ready), 32'd0);
    check("rst_alu_a", 32'(cur_alu_a), 32'd0);
    check("rst_alu_b", 32'(cur_alu_b), 32'd0);
    check("rst_state", 32'(cur_state), 32'd0);
    exp_q.delete();
    model_last = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // driver: present a request and accept it at the next edge (called #1 after an edge, DUT idle)
  task automatic accept_txn(input logic [1:0] v, input logic [1:0] op0, input logic [W-1:0] a0,
                            input logic [W-1:0] b0, input logic [1:0] op1,
                            input logic [W-1:0] a1, input logic [W-1:0] b1,
                            input logic [1:0] exp_ready, input logic [W-1:0] exp_qv);
    drv_valid = v;
    drv_op = {op1, op0};
    drv_a = {a1, a0};
    drv_b = {b1, b0};
    drv_rsp_ready = 1'b1;
    @(negedge clk);
    check("grant_ready", 32'(cur_ready), 32'(exp_ready));
    exp_q.push_back({exp_ready[1], exp_qv});
    model_last = exp_ready[1];
    @(posedge clk);
    #1;
    check("wait_busy", 32'(cur_busy), 32'd1);
    check("wait_ready", 32'(cur_ready), 32'd0);
  endtask

  // wait for the result, optionally stall the consumer, then take it and compare
  task automatic finish_txn(input int bp);
    int n;
    logic [7:0] head;
    n = 0;
    while (cur_rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat_of(sel) + 1));
    if (cur_rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: got response with no expected entry");
      end else begin
        void'(exp_q.pop_front());
      end
      drv_valid = 2'b00;
      return;
    end
    head = exp_q[0];
    if (bp > 0) drv_rsp_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      check("bp_rsp_valid", 32'(cur_rsp_valid), 32'd1);
      check("bp_rsp_id", 32'(cur_rsp_id), 32'(head[7]));
      check("bp_rsp_q", 32'(cur_rsp_q), 32'(head[6:0]));
      check("bp_ready", 32'(cur_ready), 32'd0);
      check("bp_busy", 32'(cur_busy), 32'd1);
      @(posedge clk);
      #1;
    end
    drv_rsp_ready = 1'b1;
    @(negedge clk);
    head = exp_q.pop_front();
    check("rsp_valid", 32'(cur_rsp_valid), 32'd1);
    check("rsp_id", 32'(cur_rsp_id), 32'(head[7]));
    check("rsp_q", 32'(cur_rsp_q), 32'(head[6:0]));
    @(posedge clk);
    #1;
    check("post_rsp_valid", 32'(cur_rsp_valid), 32'd0);
    check("post_state_idle", 32'(cur_state), 32'd0);
    drv_valid = 2'b00;
  endtask

  typedef struct {
    logic [1:0]   v;
    logic [1:0]   op0;
    logic [W-1:0] a0, b0;
    logic [1:0]   op1;
    logic [W-1:0] a1, b1;
    logic [1:0]   exp_ready;
    logic [W-1:0] exp_q;
    int           bp;
  } vec_t;

  vec_t tbl[10];

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    logic [1:0] v, op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic g;

    // op codes: 0 AND, 1 OR, 2 XOR, 3 NOR; table starts right after a reset
    tbl[0] = '{2'b10, 2'd0, 7'h00, 7'h00, 2'd1, 7'h01, 7'h40, 2'b10, 7'h41, 0};
    tbl[1] = '{2'b11, 2'd3, 7'h00, 7'h00, 2'd2, 7'h7F, 7'h0F, 2'b01, 7'h7F, 0};
    tbl[2] = '{2'b11, 2'd3, 7'h00, 7'h00, 2'd2, 7'h7F, 7'h0F, 2'b10, 7'h70, 0};
    tbl[3] = '{2'b11, 2'd3, 7'h00, 7'h00, 2'd2, 7'h7F, 7'h0F, 2'b01, 7'h7F, 0};
    tbl[4] = '{2'b11, 2'd3, 7'h00, 7'h00, 2'd2, 7'h7F, 7'h0F, 2'b10, 7'h70, 0};
    tbl[5] = '{2'b01, 2'd0, 7'h55, 7'h0F, 2'd0, 7'h00, 7'h00, 2'b01, 7'h05, 5};
    tbl[6] = '{2'b10, 2'd0, 7'h00, 7'h00, 2'd2, 7'h2A, 7'h15, 2'b10, 7'h3F, 1};
    tbl[7] = '{2'b11, 2'd1, 7'h00, 7'h00, 2'd0, 7'h7F, 7'h7F, 2'b01, 7'h00, 0};
    tbl[8] = '{2'b11, 2'd1, 7'h00, 7'h00, 2'd0, 7'h7F, 7'h7F, 2'b10, 7'h7F, 2};
    tbl[9] = '{2'b01, 2'd3, 7'h7F, 7'h00, 2'd0, 7'h00, 7'h00, 2'b01, 7'h00, 0};

    // reset and single AND operation from requester 0
    sel = 1;
    do_reset();
    accept_txn(2'b01, 2'd0, 7'h55, 7'h0F, 2'd0, 7'h00, 7'h00, 2'b01, 7'h05);
    finish_txn(0);

    // table-driven vectors: contention, backpressure, boundaries
    do_reset();
    for (int i = 0; i < 10; i++) begin
      accept_txn(tbl[i].v, tbl[i].op0, tbl[i].a0, tbl[i].b0, tbl[i].op1, tbl[i].a1,
                 tbl[i].b1, tbl[i].exp_ready, tbl[i].exp_q);
      finish_txn(tbl[i].bp);
    end

    // reset during WAIT discards the operation
    accept_txn(2'b01, 2'd0, 7'h55, 7'h0F, 2'd0, 7'h00, 7'h00, 2'b01, 7'h05);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(cur_rsp_valid), 32'd0);
    check("midrst_busy", 32'(cur_busy), 32'd0);
    check("midrst_alu_a", 32'(cur_alu_a), 32'd0);
    exp_q.delete();
    model_last = 1'b1;
    drv_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (cur_rsp_valid !== 1'b0) pulses++;
    end
    check("midrst_no_pulse", 32'(pulses), 32'd0);
    @(posedge clk);
    #1;
    accept_txn(2'b10, 2'd0, 7'h00, 7'h00, 2'd1, 7'h01, 7'h40, 2'b10, 7'h41);
    finish_txn(0);

    // random traffic with the bench's own grant and unit model
    for (int i = 0; i < 8; i++) begin
      v = 2'($urandom_range(1, 3));
      op0 = 2'($urandom_range(0, 3));
      op1 = 2'($urandom_range(0, 3));
      a0 = 7'($urandom_range(0, 127));
      b0 = 7'($urandom_range(0, 127));
      a1 = 7'($urandom_range(0, 127));
      b1 = 7'($urandom_range(0, 127));
      g = (v == 2'b01) ? 1'b0 : (v == 2'b10) ? 1'b1 : ~model_last;
      accept_txn(v, op0, a0, b0, op1, a1, b1, g ? 2'b10 : 2'b01,
                 g ? alu_f(op1, a1, b1) : alu_f(op0, a0, b0));
      finish_txn(int'($urandom_range(0, 2)));
    end

    // latency sweep: 0 and 3
    for (int s = 0; s <= 2; s += 2) begin
      sel = s;
      do_reset();
      accept_txn(2'b01, 2'd2, 7'h2A, 7'h55, 2'd0, 7'h00, 7'h00, 2'b01, 7'h7F);
      finish_txn(0);
      accept_txn(2'b10, 2'd0, 7'h00, 7'h00, 2'd0, 7'h7F, 7'h3C, 2'b10, 7'h3C);
      finish_txn(1);
      accept_txn(2'b11, 2'd3, 7'h00, 7'h00, 2'd2, 7'h7F, 7'h0F, 2'b01, 7'h7F);
      finish_txn(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
